// File: rtl/data_ram_agent_if.sv
// Avalon-MM read/write bus between the CPU memory unit (host) and a memory agent.
interface AvalonMmRw;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] host_to_agent;
    logic [31:0] agent_to_host;
    logic        waitrequest;

    modport Host (
        output address, read, write, byteenable, host_to_agent,
        input  agent_to_host, waitrequest
    );

    modport Agent (
        input  address, read, write, byteenable, host_to_agent,
        output agent_to_host, waitrequest
    );
endinterface

// File: rtl/data_ram_agent.sv
// Word-organised RAM on an Avalon-MM agent port with byte-enable writes,
// a fixed number of wait states per transfer and a sticky range-error flag.
module data_ram_agent #(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE        = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic      clk,
    input  logic      rst,
    AvalonMmRw.Agent  port,
    output logic      busy,
    output logic      range_error
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [33:0] SPAN = 34'(DEPTH) << 2;
    localparam logic [3:0]  WS   = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    cnt;
    logic [3:0]    cnt_nxt;
    logic [31:0]   rdata;
    logic [31:0]   offset;
    logic          in_range;
    logic [AW-1:0] idx;
    logic          req;
    logic          is_read;

    logic [31:0]   mem [DEPTH];

    // Address decode: below-BASE addresses wrap to huge offsets and fail the span test.
    assign offset   = port.address - BASE;
    assign in_range = {2'b00, offset} < SPAN;
    assign idx      = offset[AW+1:2];
    assign req      = port.read | port.write;
    assign is_read  = port.read & ~port.write;

    assign port.waitrequest   = (state != ACK);
    assign port.agent_to_host = rdata;
    assign busy               = (state != IDLE);

    // State and wait-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: count wait states, tolerate the host dropping its request.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    cnt_nxt   = WS;
                    state_nxt = (WS == '0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (!req) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_nxt = ACK;
                    end
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Read data register: loaded on the edge entering ACK, zero everywhere else.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (state_nxt == ACK && is_read && in_range) begin
            rdata <= mem[idx];
        end else begin
            rdata <= '0;
        end
    end

    // Byte-lane write on the edge ending ACK; a coincident reset cancels the commit.
    always_ff @(posedge clk) begin
        if (!rst && state == ACK && port.write && in_range) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (port.byteenable[i]) begin
                    mem[idx][8*i +: 8] <= port.host_to_agent[8*i +: 8];
                end
            end
        end
    end

    // Sticky out-of-range flag, set when an out-of-range transfer completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            range_error <= 1'b0;
        end else if (state == ACK && req && !in_range) begin
            range_error <= 1'b1;
        end
    end

endmodule

// File: doc/data_ram_agent.md
# data_ram_agent

Avalon-MM agent that terminates the CPU's data-manager port. It is a word-organised RAM with byte-enable writes and a configurable number of wait states. The far end is the CPU's memory unit, which acts as host; this block implements the responder side of the same `AvalonMmRw` interface. It also stands in for slow on-chip memory when the CPU stall path is exercised.

## Interface
Parameters:
- `DEPTH`, 1024: RAM size in 32-bit words; power of two, minimum 4.
- `BASE`, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.
- `WAIT_STATES`, 1: extra cycles `waitrequest` is held high per transfer; range 0..15.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `port`  modport `AvalonMmRw.Agent`: uses `address`[31:0], `read`, `write`, `byteenable`[3:0], `host_to_agent`[31:0], `agent_to_host`[31:0], `waitrequest`.
- `busy`  out  1: high while a transfer is in progress (states WAIT or ACK).
- `range_error`  out  1: sticky; set on any access outside [BASE, BASE+4*DEPTH); cleared only by `rst`.

## Operation
- Word index is `(address - BASE) >> 2`, computed in 32-bit unsigned arithmetic. `address[1:0]` is ignored.
- An access is in range iff `address - BASE < 4*DEPTH` (unsigned). This rejects addresses below `BASE` through wrap-around.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: `waitrequest`=1. If `read|write`, load the wait counter with `WAIT_STATES`. Go to ACK when `WAIT_STATES`==0, otherwise go to WAIT.
  - WAIT: `waitrequest`=1. The counter decrements each cycle; when it reaches 1, go to ACK next cycle.
  - WAIT abort: if the host drops both `read` and `write`, return to IDLE with no side effects. This is a protocol violation and is tolerated silently.
  - ACK: `waitrequest`=0 for exactly one cycle; the transfer completes here. Next state is always IDLE; back-to-back requests are accepted from IDLE in the following cycle.
- Write, in range: on the clock edge ending ACK, each byte lane `i` with `byteenable[i]`=1 is written from `host_to_agent[8i+7:8i]`. Other lanes are unchanged.
- Read, in range: the RAM word is registered on the edge entering ACK. `agent_to_host` presents it during ACK and reads all 32 bits regardless of `byteenable`.
- Out of range: writes are discarded and reads return 32'h0. `range_error` sets on the edge ending ACK.
- `read` and `write` asserted together: treated as a write, with `agent_to_host`=0 in ACK.
- `agent_to_host` is 0 in every state except a read ACK.
- Address and `host_to_agent` are sampled at the ACK edge. The host must hold them stable while `waitrequest`=1.
- RAM contents are not reset and start as X. The bench preloads them through hierarchical access or `$readmemh`.

## Timing
- Reset values: state IDLE, `waitrequest`=1, `agent_to_host`=0, `busy`=0, `range_error`=0, wait counter 0.
- A reset asserted mid-transfer forces IDLE on the next edge. A pending write is not committed.
- Latency: a request first seen in IDLE at cycle 0 gets `waitrequest`=0 at cycle `WAIT_STATES`+1.
- Throughput: one transfer per `WAIT_STATES`+2 cycles.
- Read-after-write to the same word in the next transfer returns the new data; the write commits before the read's data capture.
- All outputs are driven from registers; there are no combinational paths from inputs to `waitrequest` or `agent_to_host`.

## Test plan
- Reset with `read`=1 held → `waitrequest`=1, `busy`=0, `agent_to_host`=0 during reset. With `WAIT_STATES`=1, the first ACK occurs 2 cycles after release.
- Full-word write then read, `WAIT_STATES`=2: write 32'hCAFE_F00D to `BASE`+8 with `byteenable`=4'hF, then read `BASE`+8 → each ACK comes 3 cycles after its request and the read returns CAFE_F00D.
- Byte lanes: preload word with 32'h1122_3344, write 32'hAABB_CCDD with `byteenable`=4'b0101 → the following read returns 32'h11BB_33DD.
- Range checks with `BASE`=32'h1000, `DEPTH`=4:
  - Read 32'h0FFC → returns 0 and `range_error`=1.
  - Write 32'h1010 → no RAM word changes.
  - Read 32'h100C → returns valid data.
- Abort and reset mid-operation, `WAIT_STATES`=3: drop `write` during WAIT → IDLE with the RAM unchanged. Repeat with `rst` pulsed in WAIT → IDLE and no commit.
- `WAIT_STATES`=0 back-to-back reads of 4 consecutive words → an ACK every 2nd cycle with correct data and no extra stall cycles.
